host_frame_demux: RTL and testbench

HOST_FRAME_DEMUX -- requirements
Module: host_frame_demux

---
 rtl/blobby_uart_pkg.sv | 37 +++
 rtl/link_watchdog.sv | 34 +++
 rtl/host_frame_demux.sv | 156 +++++++++++++++
 tb/tb_host_frame_demux.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blobby_uart_pkg.sv
// Shared definitions for the host UART link: frame sync word, word tags,
// frame length and the deframer state encoding (also used by uart_mux).
// Build option: define HOST_FRAME_CHECKSUM_EN to add the trailing checksum word W6.
package blobby_uart_pkg;

  localparam logic [15:0] SYNC_WORD = 16'hB10B;

  localparam logic [3:0] TAG_PL1X  = 4'h1;
  localparam logic [3:0] TAG_PL1Y  = 4'h2;
  localparam logic [3:0] TAG_BALLX = 4'h3;
  localparam logic [3:0] TAG_BALLY = 4'h4;
  localparam logic [3:0] TAG_SCORE = 4'h5;
  localparam logic [3:0] TAG_CSUM  = 4'h6;

  // Words per frame, sync word included.
`ifdef HOST_FRAME_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = 7;
`else
  localparam int unsigned FRAME_LEN = 6;
`endif

  // Tag of the final word of a frame.
  localparam logic [3:0] LAST_TAG = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    StHunt    = 2'd0,
    StCollect = 2'd1,
    StCommit  = 2'd2
  } frame_state_e;

  function automatic logic [11:0] payload_xor(input logic [11:0] a, input logic [11:0] b,
                                              input logic [11:0] c, input logic [11:0] d,
                                              input logic [11:0] e);
    return a ^ b ^ c ^ d ^ e;
  endfunction

endpackage

// File: rtl/link_watchdog.sv
// Link watchdog: counts cycles since the last kick, saturating at TIMEOUT_CYCLES.
// Ports: clk, rst (async, active-high), kick (clears the count),
//        expired (count at limit, or no kick seen since reset).
module link_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 6_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] count_q;
  logic            seen_q;   // a kick has arrived since reset

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      seen_q  <= 1'b0;
    end else if (kick) begin
      count_q <= '0;
      seen_q  <= 1'b1;
    end else if (count_q != Limit) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Link is reported lost from reset until the first good frame.
  assign expired = !seen_q || (count_q == Limit);

endmodule

// File: rtl/host_frame_demux.sv
// Host frame deframer: hunts for SYNC_WORD, collects tagged words W1..W5
// (plus checksum W6 when HOST_FRAME_CHECKSUM_EN is defined) into shadow
// registers and commits them to the outputs atomically in one cycle.
// Ports: clk, rst (async, active-high); data_in/data_valid from the UART;
//        committed positions, scores and host flags; frame_valid/frame_err
//        one-cycle pulses; link_lost level from the watchdog.
module host_frame_demux
  import blobby_uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 6_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic [11:0] pl1_posx,
  output logic [11:0] pl1_posy,
  output logic [11:0] ball_posx,
  output logic [11:0] ball_posy,
  output logic [3:0]  pl1_score,
  output logic [3:0]  pl2_score,
  output logic        flag_point,
  output logic        end_game,
  output logic        host_con_broken,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        link_lost
);

  frame_state_e state_q;
  logic [3:0]   idx_q;
  logic [11:0]  sh_px, sh_py, sh_bx, sh_by;
  logic [11:0]  w5_src;
  logic         last_ok;

  logic [3:0]  tag;
  logic [11:0] payload;
  assign tag     = data_in[15:12];
  assign payload = data_in[11:0];

`ifdef HOST_FRAME_CHECKSUM_EN
  logic [11:0] sh_w5;
  assign w5_src  = sh_w5;
  assign last_ok = (payload == payload_xor(sh_px, sh_py, sh_bx, sh_by, sh_w5));
`else
  // Without a checksum the score word is the last word and commits straight from the bus.
  assign w5_src  = payload;
  assign last_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StHunt;
      idx_q           <= 4'd0;
      sh_px           <= '0;
      sh_py           <= '0;
      sh_bx           <= '0;
      sh_by           <= '0;
`ifdef HOST_FRAME_CHECKSUM_EN
      sh_w5           <= '0;
`endif
      pl1_posx        <= '0;
      pl1_posy        <= '0;
      ball_posx       <= '0;
      ball_posy       <= '0;
      pl1_score       <= '0;
      pl2_score       <= '0;
      flag_point      <= 1'b0;
      end_game        <= 1'b0;
      host_con_broken <= 1'b0;
      frame_valid     <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      unique case (state_q)
        // The commit cycle also hunts, so a sync word right after a frame is not lost.
        StHunt, StCommit: begin
          state_q <= StHunt;
          idx_q   <= 4'd0;
          if (data_valid && data_in == SYNC_WORD) begin
            state_q <= StCollect;
            idx_q   <= TAG_PL1X;
          end
        end
        StCollect: begin
          if (data_valid) begin
            if (tag == idx_q) begin
              if (idx_q == LAST_TAG) begin
                idx_q <= 4'd0;
                if (last_ok) begin
                  state_q         <= StCommit;
                  frame_valid     <= 1'b1;
                  pl1_posx        <= sh_px;
                  pl1_posy        <= sh_py;
                  ball_posx       <= sh_bx;
                  ball_posy       <= sh_by;
                  pl1_score       <= w5_src[11:8];
                  pl2_score       <= w5_src[7:4];
                  flag_point      <= w5_src[3];
                  end_game        <= w5_src[2];
                  host_con_broken <= w5_src[1];
                end else begin
                  state_q   <= StHunt;
                  frame_err <= 1'b1;
                end
              end else begin
                idx_q <= idx_q + 4'd1;
                case (idx_q)
                  TAG_PL1X:  sh_px <= payload;
                  TAG_PL1Y:  sh_py <= payload;
                  TAG_BALLX: sh_bx <= payload;
                  TAG_BALLY: sh_by <= payload;
`ifdef HOST_FRAME_CHECKSUM_EN
                  TAG_SCORE: sh_w5 <= payload;
`endif
                  default: ;
                endcase
              end
            end else begin
              // Out-of-sequence word: drop the partial frame; a sync word restarts it.
              frame_err <= 1'b1;
              sh_px     <= '0;
              sh_py     <= '0;
              sh_bx     <= '0;
              sh_by     <= '0;
`ifdef HOST_FRAME_CHECKSUM_EN
              sh_w5     <= '0;
`endif
              if (data_in == SYNC_WORD) begin
                idx_q <= TAG_PL1X;
              end else begin
                state_q <= StHunt;
                idx_q   <= 4'd0;
              end
            end
          end
        end
        default: begin
          state_q <= StHunt;
          idx_q   <= 4'd0;
        end
      endcase
    end
  end

  link_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_link_watchdog (
    .clk     (clk),
    .rst     (rst),
    .kick    (frame_valid),
    .expired (link_lost)
  );

endmodule

// File: tb/tb_host_frame_demux.sv
// Directed bench for host_frame_demux: a table of frames with hand-computed
// expected outputs, plus sequences for resync, back-to-back frames, watchdog,
// reset mid-frame and (when built with HOST_FRAME_CHECKSUM_EN) checksum errors.
module tb_host_frame_demux;

  localparam int unsigned TIMEOUT = 100;
`ifdef HOST_FRAME_CHECKSUM_EN
  localparam int NW = 7;
`else
  localparam int NW = 6;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic        data_valid;
  logic [11:0] pl1_posx, pl1_posy, ball_posx, ball_posy;
  logic [3:0]  pl1_score, pl2_score;
  logic        flag_point, end_game, host_con_broken;
  logic        frame_valid, frame_err, link_lost;

  host_frame_demux #(
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .pl1_posx        (pl1_posx),
    .pl1_posy        (pl1_posy),
    .ball_posx       (ball_posx),
    .ball_posy       (ball_posy),
    .pl1_score       (pl1_score),
    .pl2_score       (pl2_score),
    .flag_point      (flag_point),
    .end_game        (end_game),
    .host_con_broken (host_con_broken),
    .frame_valid     (frame_valid),
    .frame_err       (frame_err),
    .link_lost       (link_lost)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;
  int fv0, fe0;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cnt <= fv_cnt + 1;
    if (frame_err === 1'b1)   fe_cnt <= fe_cnt + 1;
  end

  logic [58:0] dut_bus;
  logic [58:0] exp_bus;
  assign dut_bus = {pl1_posx, pl1_posy, ball_posx, ball_posy, pl1_score, pl2_score,
                    flag_point, end_game, host_con_broken};

  typedef struct {
    logic [11:0] px, py, bx, by, w5;
    int          bad_idx;   // word whose tag gets replaced, 0 = none
    logic [3:0]  bad_tag;
    int          gap;       // idle cycles between words
    bit          commit;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Drive one word; returns just after the sampling edge.
  task automatic send(input logic [15:0] w);
    @(negedge clk);
    data_in    = w;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [11:0] px, input logic [11:0] py, input logic [11:0] bx,
                            input logic [11:0] by, input logic [11:0] w5, input int bad_idx,
                            input logic [3:0] bad_tag, input int gap, input bit flip_csum,
                            input int first);
    logic [15:0] w [7];
    w[0] = 16'hB10B;
    w[1] = {4'h1, px};
    w[2] = {4'h2, py};
    w[3] = {4'h3, bx};
    w[4] = {4'h4, by};
    w[5] = {4'h5, w5};
    w[6] = {4'h6, px ^ py ^ bx ^ by ^ w5 ^ {11'd0, flip_csum}};
    if (bad_idx != 0) w[bad_idx][15:12] = bad_tag;
    for (int i = first; i < NW; i++) begin
      send(w[i]);
      if (gap > 0 && i != NW - 1) idle(gap);
    end
  endtask

  function automatic logic [58:0] model(input logic [11:0] px, input logic [11:0] py,
                                        input logic [11:0] bx, input logic [11:0] by,
                                        input logic [11:0] w5);
    return {px, py, bx, by, w5[11:1]};
  endfunction

  initial begin
    vecs[0] = '{12'h064, 12'h200, 12'h200, 12'h100, 12'h128, 0, 4'h0, 0, 1'b1};
    vecs[1] = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h0AA, 3, 4'h4, 0, 1'b0};
    vecs[2] = '{12'hABC, 12'h123, 12'h456, 12'h789, 12'h3F6, 0, 4'h0, 2, 1'b1};
    vecs[3] = '{12'h0F0, 12'h0F1, 12'h0F2, 12'h0F3, 12'h0F4, 5, 4'h0, 1, 1'b0};
    vecs[4] = '{12'h800, 12'hFFF, 12'h001, 12'h7FE, 12'hF0E, 0, 4'h0, 0, 1'b1};
    vecs[5] = '{12'h555, 12'hAAA, 12'h5A5, 12'hA5A, 12'h124, 1, 4'h2, 0, 1'b0};

    // Reset state
    rst        = 1'b1;
    data_in    = 16'h0000;
    data_valid = 1'b0;
    #1;
    check("rst_fields", 64'(dut_bus), 64'd0);
    check("rst_frame_valid", 64'(frame_valid), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_link_lost", 64'(link_lost), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(5);
    @(negedge clk);
    check("post_rst_link_lost", 64'(link_lost), 64'd1);
    exp_bus = '0;

    // Table of frames
    for (int v = 0; v < 6; v++) begin
      fv0 = fv_cnt;
      fe0 = fe_cnt;
      send_frame(vecs[v].px, vecs[v].py, vecs[v].bx, vecs[v].by, vecs[v].w5,
                 vecs[v].bad_idx, vecs[v].bad_tag, vecs[v].gap, 1'b0, 0);
      @(negedge clk);
      check("commit_cycle_valid", 64'(frame_valid), 64'(vecs[v].commit));
      if (vecs[v].commit)
        exp_bus = model(vecs[v].px, vecs[v].py, vecs[v].bx, vecs[v].by, vecs[v].w5);
      check("commit_cycle_fields", 64'(dut_bus), 64'(exp_bus));
      if (v == 0) check("first_commit_link_lost", 64'(link_lost), 64'd1);
      idle(3);
      @(negedge clk);
      check("vec_fv_count", 64'(fv_cnt - fv0), 64'(vecs[v].commit));
      check("vec_fe_count", 64'(fe_cnt - fe0), 64'(!vecs[v].commit));
      check("vec_fields_hold", 64'(dut_bus), 64'(exp_bus));
      check("vec_link_lost", 64'(link_lost), 64'd0);
    end

    // Sync, W1, sync again, then W1..W5 of the restarted frame
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    send(16'hB10B);
    send({4'h1, 12'h111});
    send(16'hB10B);
    send_frame(12'h0AA, 12'h0BB, 12'h0CC, 12'h0DD, 12'h0C4, 0, 4'h0, 0, 1'b0, 1);
    idle(3);
    @(negedge clk);
    exp_bus = model(12'h0AA, 12'h0BB, 12'h0CC, 12'h0DD, 12'h0C4);
    check("resync_fe_count", 64'(fe_cnt - fe0), 64'd1);
    check("resync_fv_count", 64'(fv_cnt - fv0), 64'd1);
    check("resync_fields", 64'(dut_bus), 64'(exp_bus));

    // Stray tag-6 word in hunt, then two frames back to back (sync in commit cycle)
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    send(16'h6123);
    send_frame(12'h001, 12'h002, 12'h003, 12'h004, 12'h050, 0, 4'h0, 0, 1'b0, 0);
    send_frame(12'h010, 12'h020, 12'h030, 12'h040, 12'h9A2, 0, 4'h0, 0, 1'b0, 0);
    @(negedge clk);
    exp_bus = model(12'h010, 12'h020, 12'h030, 12'h040, 12'h9A2);
    check("b2b_second_valid", 64'(frame_valid), 64'd1);
    idle(3);
    @(negedge clk);
    check("b2b_fv_count", 64'(fv_cnt - fv0), 64'd2);
    check("b2b_fe_count", 64'(fe_cnt - fe0), 64'd0);
    check("b2b_fields", 64'(dut_bus), 64'(exp_bus));

    // Watchdog: link_lost exactly TIMEOUT cycles after the commit cycle ends
    send_frame(12'h321, 12'h654, 12'h987, 12'hCBA, 12'h2E0, 0, 4'h0, 0, 1'b0, 0);
    @(negedge clk);
    exp_bus = model(12'h321, 12'h654, 12'h987, 12'hCBA, 12'h2E0);
    @(negedge clk);
    check("wd_count0_link", 64'(link_lost), 64'd0);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("wd_count99_link", 64'(link_lost), 64'd0);
    @(negedge clk);
    check("wd_count100_link", 64'(link_lost), 64'd1);
    idle(20);
    @(negedge clk);
    check("wd_lost_fields_hold", 64'(dut_bus), 64'(exp_bus));
    send_frame(12'h00F, 12'h0F0, 12'hF00, 12'hFF0, 12'h018, 0, 4'h0, 1, 1'b0, 0);
    @(negedge clk);
    exp_bus = model(12'h00F, 12'h0F0, 12'hF00, 12'hFF0, 12'h018);
    check("wd_commit_valid", 64'(frame_valid), 64'd1);
    check("wd_commit_link_still", 64'(link_lost), 64'd1);
    @(negedge clk);
    check("wd_link_cleared", 64'(link_lost), 64'd0);

    // Reset between W2 and W3: frame dropped silently
    send(16'hB10B);
    send({4'h1, 12'h777});
    send({4'h2, 12'h888});
    @(negedge clk);
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    rst = 1'b1;
    #1;
    check("midrst_fields", 64'(dut_bus), 64'd0);
    check("midrst_link_lost", 64'(link_lost), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    send({4'h3, 12'h999});
    send({4'h4, 12'hAAA});
    send({4'h5, 12'h120});
    idle(3);
    @(negedge clk);
    check("midrst_fe_count", 64'(fe_cnt - fe0), 64'd0);
    check("midrst_fv_count", 64'(fv_cnt - fv0), 64'd0);
    check("midrst_fields_zero", 64'(dut_bus), 64'd0);
    check("midrst_link_after", 64'(link_lost), 64'd1);
    send_frame(12'h246, 12'h8AC, 12'h135, 12'h79B, 12'h4A8, 0, 4'h0, 0, 1'b0, 0);
    @(negedge clk);
    exp_bus = model(12'h246, 12'h8AC, 12'h135, 12'h79B, 12'h4A8);
    check("postrst_commit_valid", 64'(frame_valid), 64'd1);
    check("postrst_fields", 64'(dut_bus), 64'(exp_bus));

`ifdef HOST_FRAME_CHECKSUM_EN
    // Corrupted checksum: error, outputs untouched
    idle(2);
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    send_frame(12'h111, 12'h222, 12'h333, 12'h444, 12'h556, 0, 4'h0, 0, 1'b1, 0);
    idle(3);
    @(negedge clk);
    check("csum_bad_fe", 64'(fe_cnt - fe0), 64'd1);
    check("csum_bad_fv", 64'(fv_cnt - fv0), 64'd0);
    check("csum_bad_fields", 64'(dut_bus), 64'(exp_bus));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
